// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and index sizing helper.
package rst_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    SW_ASSERT = 2'd3
  } state_t;

  // Domain index width; a single domain still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Software-reset handshake and sequenced reset outputs of the reset sequencer.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOM = 3
);
  logic               sw_rst_req;
  logic               sw_rst_ack;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               seq_busy;
  logic               sys_ready;

  // master: software/requester side; slave: the sequencer
  modport master (
    output sw_rst_req,
    input  sw_rst_ack, dom_rst_n, seq_busy, sys_ready
  );
  modport slave (
    input  sw_rst_req,
    output sw_rst_ack, dom_rst_n, seq_busy, sys_ready
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets, then releases them one by one in index
// order with a fixed gap; a software request re-asserts everything and reruns it.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int NUM_DOM  = 3,
  parameter int HOLD_CYC = 4,
  parameter int REL_DLY  = 8,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rst_seq_ctrl_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_DOM);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [NUM_DOM-1:0] dom_reg, dom_next;
  logic               busy_reg, busy_next;
  logic               ready_reg, ready_next;
  logic               ack_reg, ack_next;

  logic               hold_done;
  logic               rel_done;
  logic               last_dom;
  logic [NUM_DOM-1:0] rel_hit;

  assign hold_done = (cnt_reg == CNT_W'(HOLD_CYC - 1));
  assign rel_done  = (cnt_reg == CNT_W'(REL_DLY - 1));
  assign last_dom  = (idx_reg == IDX_W'(NUM_DOM - 1));

  // One-hot of the domain that releases on this edge, if any.
  generate
    for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_hit
      assign rel_hit[gi] = rel_done && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HOLD;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      dom_reg   <= '0;
      busy_reg  <= 1'b1;
      ready_reg <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      dom_reg   <= dom_next;
      busy_reg  <= busy_next;
      ready_reg <= ready_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HOLD:      if (hold_done) state_next = RELEASE;
      RELEASE:   if (rel_done && last_dom) state_next = RUN;
      RUN:       if (bus.sw_rst_req) state_next = SW_ASSERT;
      SW_ASSERT: state_next = HOLD;
      default:   state_next = HOLD;
    endcase
  end

  always_comb begin
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    dom_next   = dom_reg;
    busy_next  = 1'b1;
    ready_next = 1'b0;
    ack_next   = 1'b0;
    case (state_reg)
      HOLD: begin
        dom_next = '0;
        cnt_next = hold_done ? '0 : cnt_reg + 1'b1;
      end
      RELEASE: begin
        cnt_next = rel_done ? '0 : cnt_reg + 1'b1;
        dom_next = dom_reg | rel_hit;
        if (rel_done) begin
          idx_next = last_dom ? '0 : idx_reg + 1'b1;
          if (last_dom) begin
            busy_next  = 1'b0;
            ready_next = 1'b1;
          end
        end
      end
      RUN: begin
        busy_next  = 1'b0;
        ready_next = 1'b1;
        if (bus.sw_rst_req) begin
          dom_next   = '0;
          busy_next  = 1'b1;
          ready_next = 1'b0;
          ack_next   = 1'b1;
        end
      end
      SW_ASSERT: begin
        cnt_next = '0;
        idx_next = '0;
        dom_next = '0;
      end
      default: begin
        cnt_next = '0;
        idx_next = '0;
        dom_next = '0;
      end
    endcase
  end

  assign bus.sw_rst_ack = ack_reg;
  assign bus.dom_rst_n  = dom_reg;
  assign bus.seq_busy   = busy_reg;
  assign bus.sys_ready  = ready_reg;

endmodule
